// File: rtl/l2_wb_pkg.sv
// l2_wb_pkg: shared widths and FSM state encoding for the L2 writeback buffer
package l2_wb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;
  typedef enum logic [2:0] {IDLE, WRESP, FWD, MEM_READ, RRESP, DRAIN} state_e;
endpackage

// File: rtl/l2_wb_entry.sv
// l2_wb_entry: single buffered dirty line with full-address match
module l2_wb_entry import l2_wb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] cmp_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] data,
  output logic              match
);
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] data_q, data_d;
  always_comb begin
    valid_d = clr ? 1'b0 : wr_en ? 1'b1 : valid_q;
    addr_d  = wr_en ? wr_addr : addr_q;
    data_d  = wr_en ? wr_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign addr  = addr_q;
  assign data  = data_q;
  assign match = valid_q && (addr_q == cmp_addr);
endmodule

// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: one-entry writeback buffer between L2 and physical memory
module l2_writeback_buffer import l2_wb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic              mem_resp,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              hit, cap, clr, ent_valid;
  logic [ADDR_W-1:0] ent_addr;
  logic [LINE_W-1:0] ent_data;

  l2_wb_entry #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_entry (
    .clk(clk), .rst_n(rst_n), .wr_en(cap), .clr(clr),
    .wr_addr(mem_address), .wr_data(mem_wdata), .cmp_addr(mem_address),
    .valid(ent_valid), .addr(ent_addr), .data(ent_data), .match(hit)
  );

  // Read address is latched so the pmem request cannot move if upstream misbehaves
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    cap     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read) begin
          state_d = hit ? FWD : MEM_READ;
          raddr_d = mem_address;
        end else if (mem_write) begin
          cap     = !ent_valid || hit;
          state_d = cap ? WRESP : DRAIN;
        end else if (ent_valid) begin
          state_d = DRAIN;
        end
      end
      MEM_READ: begin
        rdata_d = pmem_resp ? pmem_rdata : rdata_q;
        state_d = pmem_resp ? RRESP : MEM_READ;
      end
      DRAIN: begin
        clr     = pmem_resp;
        state_d = pmem_resp ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      raddr_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_resp     = state_q inside {WRESP, FWD, RRESP};
  assign mem_rdata    = state_q == FWD ? ent_data : state_q == RRESP ? rdata_q : '0;
  assign pmem_read    = state_q == MEM_READ;
  assign pmem_write   = state_q == DRAIN;
  assign pmem_address = pmem_read ? raddr_q : pmem_write ? ent_addr : '0;
  assign pmem_wdata   = pmem_write ? ent_data : '0;
endmodule
